// File: rtl/m_rf_wb_ctrl_pkg.sv
// Core-wide constants for the register-file writeback path.
// This package also holds the scoreboard lookup helper shared by the hazard logic.
package m_rf_wb_ctrl_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);
  localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

  // x0 is hard-wired, so it can never be pending regardless of the busy vector
  function automatic logic reg_pending(input logic [REG_AW-1:0] idx,
                                       input logic [NREG-1:0]   busy);
    return (idx != X0) && busy[idx];
  endfunction
endpackage

// File: rtl/m_rr_arb2.sv
// Two-requester round-robin arbiter; A wins the first tie after reset.
module m_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_b_q, last_b_d;

  // grant and pointer update; the pointer only moves on a real grant
  always_comb begin
    gnt_a    = req_a & (~req_b | last_b_q);
    gnt_b    = req_b & ~gnt_a;
    last_b_d = last_b_q;
    if (gnt_b) begin
      last_b_d = 1'b1;
    end else if (gnt_a) begin
      last_b_d = 1'b0;
    end else begin
      last_b_d = last_b_q;
    end
  end

  // last-grant register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
endmodule

// File: rtl/m_rf_wb_ctrl.sv
// Writeback arbiter and register scoreboard between issue, execution units and the RF.
// Results land in the RF one cycle after acceptance and are readable one cycle later.
module m_rf_wb_ctrl
  import m_rf_wb_ctrl_pkg::*;
(
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_is_valid,
  input  logic [4:0]        w_is_rs1,
  input  logic [4:0]        w_is_rs2,
  input  logic [4:0]        w_is_rd,
  input  logic              w_is_we,
  output logic              w_stall,
  input  logic              w_a_valid,
  input  logic [4:0]        w_a_wa,
  input  logic [XLEN-1:0]   w_a_wd,
  output logic              w_a_ready,
  input  logic              w_b_valid,
  input  logic [4:0]        w_b_wa,
  input  logic [XLEN-1:0]   w_b_wd,
  output logic              w_b_ready,
  output logic              w_rf_we,
  output logic [4:0]        w_rf_wa,
  output logic [XLEN-1:0]   w_rf_wd,
  output logic [NREG-1:0]   w_busy
);
  logic              gnt_a_s, gnt_b_s;
  logic              stall_s, issue_set_s;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wa_q, rf_wa_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
  logic [NREG-1:0]   busy_q, busy_d;

  m_rr_arb2 u_arb (
    .clk   (w_clk),
    .rst_n (w_rst_n),
    .req_a (w_a_valid),
    .req_b (w_b_valid),
    .gnt_a (gnt_a_s),
    .gnt_b (gnt_b_s)
  );

  // RAW on either source, WAW on the destination
  always_comb begin
    stall_s = w_is_valid & (reg_pending(w_is_rs1, busy_q) |
                            reg_pending(w_is_rs2, busy_q) |
                            (w_is_we & reg_pending(w_is_rd, busy_q)));
    issue_set_s = w_is_valid & w_is_we & (w_is_rd != X0) & ~stall_s;
  end

  // x0 results are consumed by the grant but never reach the RF
  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (gnt_a_s && (w_a_wa != X0)) begin
      rf_we_d = 1'b1;
      rf_wa_d = w_a_wa;
      rf_wd_d = w_a_wd;
    end else if (gnt_b_s && (w_b_wa != X0)) begin
      rf_we_d = 1'b1;
      rf_wa_d = w_b_wa;
      rf_wd_d = w_b_wd;
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // clear on the RF write edge, then set so a coincident issue wins
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_wa_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_set_s) begin
      busy_d[w_is_rd] = 1'b1;
    end else begin
      busy_d[w_is_rd] = busy_d[w_is_rd];
    end
    busy_d[0] = 1'b0;
  end

  // scoreboard and RF write-port registers
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      busy_q  <= {NREG{1'b0}};
      rf_we_q <= 1'b0;
      rf_wa_q <= {REG_AW{1'b0}};
      rf_wd_q <= {XLEN{1'b0}};
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  assign w_stall   = stall_s;
  assign w_a_ready = gnt_a_s;
  assign w_b_ready = gnt_b_s;
  assign w_rf_we   = rf_we_q;
  assign w_rf_wa   = rf_wa_q;
  assign w_rf_wd   = rf_wd_q;
  assign w_busy    = busy_q;
endmodule
